unidade_controle_vidas: RTL and testbench

// Next-generation control FSM for the sequence-memory game; drives the same datapath
// (sequence counter, limit counter, move register, memory, display and timeout timers).

---
 rtl/unidade_controle_vidas.sv | 189 ++++++++++++++++++
 tb/tb_unidade_controle_vidas.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_vidas.sv
// unidade_controle_vidas
// Moore control FSM for the sequence-memory game, with lives, a saturating score and a
// run-time timeout enable. It drives the existing datapath: the sequence and limit counters,
// the move register, the memory, the display timer and the timeout timer.
//
// Ports
//   clock, reset                  rising-edge clock; asynchronous active-high reset
//   iniciar                       start, or restart from any final state
//   jogada                        one-cycle move strobe
//   igual, fimRodada, fimTotal    datapath compare and counter status
//   fimTimeout, fimExibicao       timer expiry flags
//   timeout_en                    1: an expired timeout costs a life; 0: wait forever
//   datapath and timer strobes    contaC, zeraC, contaCL, zeraCL, registraR, zeraR, escreve,
//                                 contaExibicao, zeraExibicao, contaTimeout, zeraTimeout
//   display, mode and edge        leds_BM, mostraLeds, registraModo, resetEdgeDetector
//   perdeu_vida                   one-cycle pulse while a life is being lost
//   acertou, errou, errou_timeout, pronto   game result flags
//   vidas, score                  lives remaining; rounds completed in this game
//   db_estado                     current state code, or 5'h1F for an illegal code
module unidade_controle_vidas #(
  parameter int LIVES   = 3,
  parameter int LIFE_W  = 2,
  parameter int SCORE_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               jogada,
  input  logic               igual,
  input  logic               fimRodada,
  input  logic               fimTotal,
  input  logic               fimTimeout,
  input  logic               fimExibicao,
  input  logic               timeout_en,
  output logic               contaC,
  output logic               zeraC,
  output logic               contaCL,
  output logic               zeraCL,
  output logic               registraR,
  output logic               zeraR,
  output logic               escreve,
  output logic               contaExibicao,
  output logic               zeraExibicao,
  output logic               contaTimeout,
  output logic               zeraTimeout,
  output logic               leds_BM,
  output logic               mostraLeds,
  output logic               registraModo,
  output logic               resetEdgeDetector,
  output logic               perdeu_vida,
  output logic               acertou,
  output logic               errou,
  output logic               errou_timeout,
  output logic               pronto,
  output logic [LIFE_W-1:0]  vidas,
  output logic [SCORE_W-1:0] score,
  output logic [4:0]         db_estado
);

  localparam logic [4:0] INICIAL       = 5'h00;
  localparam logic [4:0] INICIALIZA    = 5'h01;
  localparam logic [4:0] PREPARA_EXIB  = 5'h02;
  localparam logic [4:0] MOSTRA        = 5'h03;
  localparam logic [4:0] INICIA_RODADA = 5'h04;
  localparam logic [4:0] ESPERA        = 5'h05;
  localparam logic [4:0] REGISTRA      = 5'h06;
  localparam logic [4:0] COMPARA       = 5'h07;
  localparam logic [4:0] PROXIMA       = 5'h08;
  localparam logic [4:0] ADICIONAL     = 5'h09;
  localparam logic [4:0] ESPERA_ADIC   = 5'h0A;
  localparam logic [4:0] REGISTRA_NOVA = 5'h0B;
  localparam logic [4:0] GRAVA         = 5'h0C;
  localparam logic [4:0] AUMENTA       = 5'h0D;
  localparam logic [4:0] VERIFICA      = 5'h0E;
  localparam logic [4:0] PERDE_VIDA    = 5'h0F;
  localparam logic [4:0] FINAL_ACERTO  = 5'h12;
  localparam logic [4:0] FINAL_ERRO    = 5'h13;
  localparam logic [4:0] FINAL_TIMEOUT = 5'h14;

  localparam logic [LIFE_W-1:0]  LIVES_V   = LIFE_W'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [4:0]         estado_q, estado_d;
  logic [LIFE_W-1:0]  vidas_q, vidas_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               err_to_q, err_to_d;
  logic               timeout_hit;

  function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

  function automatic logic [LIFE_W-1:0] vidas_floor_dec(input logic [LIFE_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  // A move strobe always wins over an expired timeout in the same cycle.
  assign timeout_hit = !jogada && timeout_en && fimTimeout;

  always_comb begin
    estado_d = INICIAL;
    case (estado_q)
      INICIAL:       estado_d = iniciar ? INICIALIZA : INICIAL;
      INICIALIZA:    estado_d = PREPARA_EXIB;
      PREPARA_EXIB:  estado_d = MOSTRA;
      MOSTRA:        estado_d = fimExibicao ? INICIA_RODADA : MOSTRA;
      INICIA_RODADA: estado_d = ESPERA;
      ESPERA:        estado_d = jogada ? REGISTRA : (timeout_hit ? PERDE_VIDA : ESPERA);
      REGISTRA:      estado_d = COMPARA;
      COMPARA:       estado_d = !igual ? PERDE_VIDA : (fimRodada ? ADICIONAL : PROXIMA);
      PROXIMA:       estado_d = ESPERA;
      ADICIONAL:     estado_d = ESPERA_ADIC;
      ESPERA_ADIC:   estado_d = jogada ? REGISTRA_NOVA : (timeout_hit ? PERDE_VIDA : ESPERA_ADIC);
      REGISTRA_NOVA: estado_d = GRAVA;
      GRAVA:         estado_d = AUMENTA;
      AUMENTA:       estado_d = VERIFICA;
      VERIFICA:      estado_d = fimTotal ? FINAL_ACERTO : INICIA_RODADA;
      // The decision uses the life count before this state's decrement lands.
      PERDE_VIDA:    estado_d = (vidas_q == LIFE_W'(1)) ? (err_to_q ? FINAL_TIMEOUT : FINAL_ERRO)
                                                        : PREPARA_EXIB;
      FINAL_ACERTO,
      FINAL_ERRO,
      FINAL_TIMEOUT: estado_d = iniciar ? INICIALIZA : estado_q;
      default:       estado_d = INICIAL;
    endcase
  end

  always_comb begin
    vidas_d  = vidas_q;
    score_d  = score_q;
    err_to_d = err_to_q;
    case (estado_q)
      INICIALIZA: begin
        vidas_d = LIVES_V;
        score_d = '0;
      end
      AUMENTA:    score_d = score_sat_inc(score_q);
      PERDE_VIDA: vidas_d = vidas_floor_dec(vidas_q);
      ESPERA, ESPERA_ADIC: if (timeout_hit) err_to_d = 1'b1;
      COMPARA:    if (!igual) err_to_d = 1'b0;
      default:    ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIAL;
      vidas_q  <= LIVES_V;
      score_q  <= '0;
      err_to_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      vidas_q  <= vidas_d;
      score_q  <= score_d;
      err_to_q <= err_to_d;
    end
  end

  assign zeraC             = estado_q inside {INICIAL, INICIALIZA, PREPARA_EXIB, INICIA_RODADA};
  assign contaC            = estado_q inside {PROXIMA, ADICIONAL};
  assign zeraR             = estado_q inside {INICIAL, INICIALIZA};
  assign registraR         = estado_q inside {REGISTRA, REGISTRA_NOVA};
  assign zeraCL            = (estado_q == INICIALIZA);
  assign contaCL           = (estado_q == AUMENTA);
  assign escreve           = (estado_q == GRAVA);
  assign leds_BM           = estado_q inside {PREPARA_EXIB, MOSTRA};
  assign mostraLeds        = (estado_q >= MOSTRA) && (estado_q <= VERIFICA);
  assign contaExibicao     = (estado_q == MOSTRA);
  assign zeraExibicao      = estado_q inside {INICIAL, INICIALIZA, PREPARA_EXIB};
  assign contaTimeout      = estado_q inside {ESPERA, ESPERA_ADIC};
  assign zeraTimeout       = estado_q inside {INICIAL, INICIALIZA, INICIA_RODADA, REGISTRA,
                                              PROXIMA, ADICIONAL, REGISTRA_NOVA, AUMENTA,
                                              PERDE_VIDA};
  assign resetEdgeDetector = estado_q inside {INICIAL, INICIALIZA};
  assign registraModo      = estado_q inside {INICIAL, FINAL_ACERTO, FINAL_ERRO, FINAL_TIMEOUT};
  assign perdeu_vida       = (estado_q == PERDE_VIDA);
  assign acertou           = (estado_q == FINAL_ACERTO);
  assign errou             = estado_q inside {FINAL_ERRO, FINAL_TIMEOUT};
  assign errou_timeout     = (estado_q == FINAL_TIMEOUT);
  assign pronto            = estado_q inside {FINAL_ACERTO, FINAL_ERRO, FINAL_TIMEOUT};
  assign vidas             = vidas_q;
  assign score             = score_q;

  // Codes 10, 11 and 15..1F are not states; flag them distinctly on the debug port.
  assign db_estado = ((estado_q <= PERDE_VIDA) ||
                      (estado_q inside {FINAL_ACERTO, FINAL_ERRO, FINAL_TIMEOUT}))
                     ? estado_q : 5'h1F;

endmodule

// File: tb/tb_unidade_controle_vidas.sv
// Directed bench for unidade_controle_vidas: a default instance (LIVES=3, SCORE_W=5) and a
// second instance with SCORE_W=2 sharing all inputs, for the score saturation case.
module tb_unidade_controle_vidas;

  logic clock = 1'b0;
  logic reset, iniciar, jogada, igual, fimRodada, fimTotal, fimTimeout, fimExibicao, timeout_en;

  logic contaC, zeraC, contaCL, zeraCL, registraR, zeraR, escreve;
  logic contaExibicao, zeraExibicao, contaTimeout, zeraTimeout;
  logic leds_BM, mostraLeds, registraModo, resetEdgeDetector, perdeu_vida;
  logic acertou, errou, errou_timeout, pronto;
  logic [1:0] vidas;
  logic [4:0] score;
  logic [4:0] db_estado;

  logic contaC2, zeraC2, contaCL2, zeraCL2, registraR2, zeraR2, escreve2;
  logic contaExibicao2, zeraExibicao2, contaTimeout2, zeraTimeout2;
  logic leds_BM2, mostraLeds2, registraModo2, resetEdgeDetector2, perdeu_vida2;
  logic acertou2, errou2, errou_timeout2, pronto2;
  logic [1:0] vidas2;
  logic [1:0] score2;
  logic [4:0] db_estado2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  unidade_controle_vidas dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .fimRodada(fimRodada), .fimTotal(fimTotal), .fimTimeout(fimTimeout),
    .fimExibicao(fimExibicao), .timeout_en(timeout_en),
    .contaC(contaC), .zeraC(zeraC), .contaCL(contaCL), .zeraCL(zeraCL),
    .registraR(registraR), .zeraR(zeraR), .escreve(escreve),
    .contaExibicao(contaExibicao), .zeraExibicao(zeraExibicao),
    .contaTimeout(contaTimeout), .zeraTimeout(zeraTimeout),
    .leds_BM(leds_BM), .mostraLeds(mostraLeds), .registraModo(registraModo),
    .resetEdgeDetector(resetEdgeDetector), .perdeu_vida(perdeu_vida),
    .acertou(acertou), .errou(errou), .errou_timeout(errou_timeout), .pronto(pronto),
    .vidas(vidas), .score(score), .db_estado(db_estado)
  );

  unidade_controle_vidas #(.LIVES(3), .LIFE_W(2), .SCORE_W(2)) dut2 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .fimRodada(fimRodada), .fimTotal(fimTotal), .fimTimeout(fimTimeout),
    .fimExibicao(fimExibicao), .timeout_en(timeout_en),
    .contaC(contaC2), .zeraC(zeraC2), .contaCL(contaCL2), .zeraCL(zeraCL2),
    .registraR(registraR2), .zeraR(zeraR2), .escreve(escreve2),
    .contaExibicao(contaExibicao2), .zeraExibicao(zeraExibicao2),
    .contaTimeout(contaTimeout2), .zeraTimeout(zeraTimeout2),
    .leds_BM(leds_BM2), .mostraLeds(mostraLeds2), .registraModo(registraModo2),
    .resetEdgeDetector(resetEdgeDetector2), .perdeu_vida(perdeu_vida2),
    .acertou(acertou2), .errou(errou2), .errou_timeout(errou_timeout2), .pronto(pronto2),
    .vidas(vidas2), .score(score2), .db_estado(db_estado2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // From INICIAL or a final state into INICIA_RODADA, display ends after 4 cycles in MOSTRA.
  task automatic start_game();
    iniciar = 1'b1; step(); iniciar = 1'b0;
    chk("start_inicializa", db_estado, 5'h01);
    step(); chk("start_prepara", db_estado, 5'h02);
    step();
    repeat (3) step();
    chk("start_mostra_hold", db_estado, 5'h03);
    fimExibicao = 1'b1; step(); fimExibicao = 1'b0;
    chk("start_inicia_rodada", db_estado, 5'h04);
  endtask

  // Entered in INICIA_RODADA; plays `moves` correct moves, adds one, ends after VERIFICA.
  task automatic do_round(input int moves, input bit last);
    step();
    for (int i = 0; i < moves; i++) begin
      jogada = 1'b1; step(); jogada = 1'b0;
      step();
      fimRodada = (i == moves - 1);
      step(); fimRodada = 1'b0;
      if (i != moves - 1) step();
    end
    step();
    jogada = 1'b1; step(); jogada = 1'b0;
    step(); step(); step();
    fimTotal = last; step(); fimTotal = 1'b0;
  endtask

  // Entered in INICIA_RODADA; a wrong first move, leaves the bench in PERDE_VIDA.
  task automatic lose_mismatch();
    step();
    jogada = 1'b1; step(); jogada = 1'b0;
    igual = 1'b0; step(); step(); igual = 1'b1;
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b1; fimRodada = 1'b0;
    fimTotal = 1'b0; fimTimeout = 1'b0; fimExibicao = 1'b0; timeout_en = 1'b0;
    step(); step();
    chk("rst_estado", db_estado, 5'h00);
    chk("rst_vidas", vidas, 2'd3);
    chk("rst_score", score, 5'd0);
    chk("rst_zeraC", zeraC, 1'b1);
    chk("rst_registraModo", registraModo, 1'b1);
    reset = 1'b0;
    step();
    chk("idle_hold", db_estado, 5'h00);

    // 1: win in three rounds
    start_game();
    chk("t1_leds_off", leds_BM, 1'b0);
    do_round(1, 1'b0);
    chk("t1_r1_back", db_estado, 5'h04);
    do_round(2, 1'b0);
    do_round(3, 1'b1);
    chk("t1_final", db_estado, 5'h12);
    chk("t1_acertou", acertou, 1'b1);
    chk("t1_pronto", pronto, 1'b1);
    chk("t1_errou", errou, 1'b0);
    chk("t1_score", score, 5'd3);
    chk("t1_vidas", vidas, 2'd3);

    // 2: one mismatch in round 2, life lost and display replayed
    start_game();
    chk("t2_vidas_reload", vidas, 2'd3);
    chk("t2_score_clear", score, 5'd0);
    do_round(1, 1'b0);
    lose_mismatch();
    chk("t2_perde_vida", db_estado, 5'h0F);
    chk("t2_pulse", perdeu_vida, 1'b1);
    chk("t2_zeraTimeout", zeraTimeout, 1'b1);
    step();
    chk("t2_replay_prepara", db_estado, 5'h02);
    chk("t2_vidas", vidas, 2'd2);
    chk("t2_pulse_end", perdeu_vida, 1'b0);
    step();
    chk("t2_replay_mostra", db_estado, 5'h03);
    chk("t2_leds_BM", leds_BM, 1'b1);
    fimExibicao = 1'b1; step(); fimExibicao = 1'b0;
    chk("t2_restart_round", db_estado, 5'h04);
    chk("t2_zeraC", zeraC, 1'b1);
    chk("t2_limit_kept", zeraCL, 1'b0);
    chk("t2_score_kept", score, 5'd1);

    // 3: two more mismatches end the game
    lose_mismatch();
    step(); step();
    fimExibicao = 1'b1; step(); fimExibicao = 1'b0;
    chk("t3_vidas1", vidas, 2'd1);
    lose_mismatch();
    step();
    chk("t3_final", db_estado, 5'h13);
    chk("t3_errou", errou, 1'b1);
    chk("t3_errou_to", errou_timeout, 1'b0);
    chk("t3_vidas0", vidas, 2'd0);
    step();
    chk("t3_hold", db_estado, 5'h13);

    // 4: timeout in ESPERA_ADIC on the last life
    timeout_en = 1'b1;
    start_game();
    lose_mismatch(); step(); step();
    fimExibicao = 1'b1; step(); fimExibicao = 1'b0;
    lose_mismatch(); step(); step();
    fimExibicao = 1'b1; step(); fimExibicao = 1'b0;
    chk("t4_vidas1", vidas, 2'd1);
    step();
    jogada = 1'b1; step(); jogada = 1'b0;
    step();
    fimRodada = 1'b1; step(); fimRodada = 1'b0;
    step();
    chk("t4_espera_adic", db_estado, 5'h0A);
    chk("t4_contaTimeout", contaTimeout, 1'b1);
    fimTimeout = 1'b1; step(); fimTimeout = 1'b0;
    chk("t4_perde_vida", db_estado, 5'h0F);
    step();
    chk("t4_final", db_estado, 5'h14);
    chk("t4_errou_to", errou_timeout, 1'b1);
    chk("t4_errou", errou, 1'b1);
    chk("t4_vidas0", vidas, 2'd0);

    // 5: timeout disabled, then jogada priority
    timeout_en = 1'b0;
    start_game();
    step();
    fimTimeout = 1'b1;
    repeat (100) step();
    chk("t5_wait_forever", db_estado, 5'h05);
    chk("t5_vidas", vidas, 2'd3);
    timeout_en = 1'b1; jogada = 1'b1; step(); jogada = 1'b0;
    fimTimeout = 1'b0; timeout_en = 1'b0;
    chk("t5_jogada_prio", db_estado, 5'h06);
    chk("t5_registraR", registraR, 1'b1);

    // 6: score saturation and asynchronous reset in GRAVA
    reset = 1'b1; step(); reset = 1'b0;
    start_game();
    for (int r = 0; r < 5; r++) do_round(1, 1'b0);
    chk("t6_score_sat", score2, 2'd3);
    chk("t6_score_wide", score, 5'd5);
    step();
    jogada = 1'b1; step(); jogada = 1'b0;
    step();
    fimRodada = 1'b1; step(); fimRodada = 1'b0;
    step();
    jogada = 1'b1; step(); jogada = 1'b0;
    step();
    chk("t6_grava", db_estado2, 5'h0C);
    chk("t6_escreve", escreve2, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_estado", db_estado2, 5'h00);
    chk("t6_async_escreve", escreve2, 1'b0);
    chk("t6_async_score", score2, 2'd0);
    step();
    reset = 1'b0;
    step();
    chk("t6_after_reset", db_estado, 5'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
